// File: rtl/im_lut_loader_if.sv
// Load-stream handshake and CPU read port for the immediate lookup table.
// The master is the host or boot streamer. The slave is im_lut_loader.
interface im_lut_loader_if #(
   parameter int DPW = 8
);
   logic           load_start;
   logic           load_abort;
   logic           load_valid;
   logic [DPW-1:0] load_data;
   logic           load_ready;
   logic [4:0]     index;
   logic [DPW-1:0] imm_value;
   logic           lut_valid;
   logic           load_busy;
   logic           load_done;
   logic [DPW-1:0] load_csum;

   modport master (
      output load_start, load_abort, load_valid, load_data, index,
      input  load_ready, imm_value, lut_valid, load_busy, load_done, load_csum
   );

   modport slave (
      input  load_start, load_abort, load_valid, load_data, index,
      output load_ready, imm_value, lut_valid, load_busy, load_done, load_csum
   );
endinterface

// File: rtl/im_lut_loader.sv
// Runtime-writable 32-entry immediate table with a streaming load controller.
// The CPU reads the table combinationally; reads return 0 until a full load has completed.
module im_lut_loader #(
   parameter int DATA_PATH_WIDTH = 8,
   parameter int LUT_SIZE        = 32
) (
   input logic            clk,
   input logic            rst_n,
   im_lut_loader_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [4:0] LAST = 5'(LUT_SIZE - 1);

   logic [1:0]                 state;
   logic [4:0]                 wr_ptr;
   logic [DATA_PATH_WIDTH-1:0] acc;
   logic [DATA_PATH_WIDTH-1:0] csum;
   logic                       valid_q;
   logic [DATA_PATH_WIDTH-1:0] entry [LUT_SIZE];
   logic                       xfer;

   // Abort takes priority, so a beat presented alongside it is dropped
   assign xfer = (state == LOAD) && bus.load_valid && !bus.load_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         acc     <= '0;
         csum    <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load_start) begin
                  state   <= LOAD;
                  wr_ptr  <= '0;
                  acc     <= '0;
                  valid_q <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.load_abort) begin
                  state <= IDLE;
               end else if (xfer) begin
                  acc    <= acc ^ bus.load_data;
                  wr_ptr <= wr_ptr + 5'd1;
                  if (wr_ptr == LAST) begin
                     state   <= DONE;
                     csum    <= acc ^ bus.load_data;
                     valid_q <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LUT_SIZE; i++) begin
            entry[i] <= '0;
         end
      end else if (xfer) begin
         entry[wr_ptr] <= bus.load_data;
      end
   end

   assign bus.load_ready = (state == LOAD);
   assign bus.load_busy  = (state == LOAD);
   assign bus.load_done  = (state == DONE);
   assign bus.lut_valid  = valid_q;
   assign bus.load_csum  = csum;
   assign bus.imm_value  = valid_q ? entry[bus.index] : '0;
endmodule
